// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and counter width for the 74x253 scan controller
package mux_scan_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_settle.sv
// rtl/mux_scan_settle.sv - settle down-counter with load, saturating decrement and zero/one flags
module mux_scan_settle
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero,
  output logic one
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= CNT_W'(SETTLE);
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);
  assign one  = (count == CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctl.sv
// rtl/mux_scan_ctl.sv - scans a 74x253 pair into an 8-bit word; MUX_SCAN_AUTO_EN enables continuous rescan
module mux_scan_ctl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] sel,
  output logic       noe1,
  output logic       noe2,
  input  logic       y1,
  input  logic       y2,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       busy
);

  state_t     state, state_n;
  logic [1:0] sel_n;
  logic       noe_n;
  logic [7:0] data_n;
  logic       valid_n, busy_n;
  logic       cnt_load, cnt_dec, cnt_zero, cnt_one;

  mux_scan_settle #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero),
    .one   (cnt_one)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sel   <= 2'd0;
      noe1  <= 1'b1;
      noe2  <= 1'b1;
      data  <= 8'h00;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      noe1  <= noe_n;
      noe2  <= noe_n;
      data  <= data_n;
      valid <= valid_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    noe_n    = noe1;
    data_n   = data;
    valid_n  = valid;
    busy_n   = busy;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_SETTLE;
          sel_n    = 2'd0;
          noe_n    = 1'b0;
          busy_n   = 1'b1;
          cnt_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        cnt_dec = 1'b1;
        // the edge that takes the count from 1 to 0 is the last settle edge
        if (cnt_one || cnt_zero)
          state_n = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // undriven or unknown mux outputs are captured as 0
        data_n[{1'b0, sel}] = (y1 === 1'b1);
        data_n[{1'b1, sel}] = (y2 === 1'b1);
        if (sel != 2'd3) begin
          sel_n    = sel + 2'd1;
          cnt_load = 1'b1;
          state_n  = ST_SETTLE;
        end else begin
          state_n = ST_DONE;
          valid_n = 1'b1;
          noe_n   = 1'b1;
        end
      end
      ST_DONE: begin
        if (ack) begin
          valid_n = 1'b0;
          sel_n   = 2'd0;
`ifdef MUX_SCAN_AUTO_EN
          state_n  = ST_SETTLE;
          noe_n    = 1'b0;
          cnt_load = 1'b1;
`else
          state_n = ST_IDLE;
          busy_n  = 1'b0;
`endif
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mux_scan_ctl.md
MUX_SCAN_CTL -- requirements
Module: mux_scan_ctl

Interface
REQ-001 Parameter SETTLE, default 1, number of settle cycles after each sel change before sampling (legal 1..15).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one scan of a 74x253 pair; sampled in IDLE only.
REQ-005 sel  output  2  select lines driven to the downstream 74x253.
REQ-006 noe1, noe2  output  1 each  active-low output enables for the 74x253 units.
REQ-007 y1, y2  input  1 each  74x253 outputs fed back for sampling.
REQ-008 data  output  8  assembled word; data[3:0] from y1, data[7:4] from y2.
REQ-009 valid  output  1  data is complete and stable.
REQ-010 ack  input  1  consumer accepts data; honoured only while valid=1.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 States SHALL be IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-013 IDLE: start=1 -> SETTLE with sel=0, noe1=noe2=0, settle count loaded with SETTLE; start=0 -> stay.
REQ-014 SETTLE: count decrements each edge; after exactly SETTLE edges in SETTLE -> SAMPLE, sel unchanged.
REQ-015 SAMPLE (one edge): data[sel] <= y1, data[4+sel] <= y2; sel<3 -> sel+1, reload count, SETTLE; sel=3 -> DONE.
REQ-016 Entering DONE: valid=1, noe1=noe2=1 (mux outputs released to z), sel held at 3.
REQ-017 Latency: valid SHALL rise on edge 4*(SETTLE+1) counted from the edge sampling start (SETTLE=1: edge 8).
REQ-018 DONE: valid and data held until ack=1; on ack edge -> IDLE, valid=0, sel=0, data held.
REQ-019 ack outside DONE ignored; start outside IDLE ignored (no restart, no queueing).
REQ-020 ack and start both high in DONE: only ack acts; start re-sampled next cycle in IDLE.
REQ-021 A y1/y2 value that is not 0/1 when sampled SHALL be stored as 0.
REQ-022 Count and sel arithmetic SHALL not wrap: sel never passes 3; count never underflows below 0.

Reset
REQ-023 On any edge with reset=1 (including mid-scan): state IDLE, sel=0, noe1=noe2=1, data=8'h00, valid=0, busy=0, count=0.
REQ-024 reset SHALL dominate start and ack in the same cycle.

Configuration
REQ-025 Macro MUX_SCAN_AUTO_EN defined: ack in DONE goes directly to SETTLE with sel=0, noe1=noe2=0, count reloaded (continuous rescan); busy stays 1.
REQ-026 MUX_SCAN_AUTO_EN undefined: ack in DONE returns to IDLE per REQ-018.

Structure
REQ-027 State encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and SETTLE width constant SHALL live in shared package mux_scan_pkg.
REQ-028 The settle down-counter SHALL be sub-module mux_scan_settle (load, decrement, zero flag).

Verification (bench instantiates mux_scan_ctl driving a mux_253)
REQ-029 SETTLE=1, i1=4'b1010, i2=4'b0110, start pulse -> valid on edge 8, data=8'h6A, noe1=noe2=1 after DONE.
REQ-030 SETTLE=3, i1=4'hF, i2=4'h0 -> valid on edge 16, data=8'h0F; sel steps 0,1,2,3 each held 4 cycles.
REQ-031 reset asserted at edge 5 of a scan -> next edge sel=0, noe1=noe2=1, valid=0, busy=0; new start gives full scan.
REQ-032 valid held 10 cycles with ack=0, i1/i2 changed meanwhile -> data unchanged; ack=1 -> IDLE next edge, valid=0.
REQ-033 start held high continuously, ack pulsed in DONE -> scans back-to-back, second valid 1+8 edges after ack (IDLE then scan); with MUX_SCAN_AUTO_EN valid 8 edges after ack.
REQ-034 ack pulsed in IDLE/SETTLE and start pulsed in SAMPLE -> no state change, no extra scan.
